// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clkdiv_enable_gen divider family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clkdiv_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 2;

  // Per-channel divisor lifecycle: settled, update waiting for a wrap, new divisor not yet pulsed
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    RELOCK = 2'd2
  } ch_state_e;

  // Width of the channel-select field; a single channel still needs one bit
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, divisor/pending registers, relock FSM, ce/sq/locked.
// Latency: ce/sq registered, one cycle after the counter state they decode.
// Backpressure: i_cfg_we is pre-qualified by the top; o_pend holds off further updates.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sync,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_ce,
  output logic             o_sq,
  output logic             o_locked,
  output logic             o_pend
);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ce;
  logic             r_sq;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_ne;
  logic [CNT_W-1:0] w_half;
  logic             w_wrap;
  logic             w_ce_nxt;
  logic             w_sq_nxt;

  // A programmed divisor of 0 behaves as divide-by-1
  assign w_ne   = (r_div == '0) ? CNT_W'(1) : r_div;
  assign w_half = w_ne >> 1;
  assign w_wrap = (r_cnt == (w_ne - CNT_W'(1)));

  // Next-state, counter and output decode; divisor swaps only on a wrap so periods are never cut
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_cnt_nxt   = w_wrap ? '0 : (r_cnt + CNT_W'(1));
    w_ce_nxt    = w_wrap;
    w_sq_nxt    = (r_cnt < w_half);
    case (r_state)
      RUN: begin
        w_state_nxt = RUN;
      end
      PEND: begin
        if (w_wrap) begin
          w_div_nxt   = r_pend_div;
          w_state_nxt = RELOCK;
        end
      end
      RELOCK: begin
        if (w_wrap) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RELOCK;
      end
    endcase
    // Phase alignment: restart at count 0, apply any waiting divisor right away
    if (i_sync) begin
      w_cnt_nxt = '0;
      if (r_state == PEND) begin
        w_div_nxt = r_pend_div;
      end
      w_state_nxt = RELOCK;
      w_ce_nxt    = 1'b0;
      w_sq_nxt    = (w_div_nxt > CNT_W'(1));
    end
    // A fresh update always parks the channel until its next wrap
    if (i_cfg_we) begin
      w_state_nxt = PEND;
    end
  end

  // State, counter, divisor and registered outputs; reset discards any waiting update
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= RELOCK;
      r_div      <= CNT_W'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_cnt      <= '0;
      r_ce       <= 1'b0;
      r_sq       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ce    <= w_ce_nxt;
      r_sq    <= w_sq_nxt;
      if (i_cfg_we) begin
        r_pend_div <= i_cfg_div;
      end
    end
  end

  assign o_ce     = r_ce;
  assign o_sq     = r_sq;
  assign o_locked = (r_state == RUN);
  assign o_pend   = (r_state == PEND);

endmodule

// File: rtl/clkdiv_enable_gen.sv
// Multi-channel programmable clock-enable / square-wave generator; optional sync port under CLKDIV_SYNC_EN.
// Latency: ce/sq registered; a new divisor takes effect at the channel's next wrap after accept.
// Backpressure: cfg_ready low while any channel holds a pending divisor; held requests wait.
module clkdiv_enable_gen
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] locked
);

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_we;
  logic              w_accept;
  logic              w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Single outstanding update across all channels
  assign cfg_ready = ~(|w_pend);
  assign w_accept  = cfg_valid & cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Out-of-range indices match nothing: handshake completes, no channel changes
    assign w_we[g] = w_accept && (cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_sync    (w_sync),
      .i_cfg_we  (w_we[g]),
      .i_cfg_div (cfg_div),
      .o_ce      (ce[g]),
      .o_sq      (sq[g]),
      .o_locked  (locked[g]),
      .o_pend    (w_pend[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_enable_gen.sv
// Directed bench for clkdiv_enable_gen. NUM_CH=3 so that cfg_ch=3 is a representable
// out-of-range index. Vectors are [ch2 ch1 ch0]; each row is the value just after edge k,
// where k=1 is the first edge with rst_n=1 after the initial reset.
module tb_clkdiv_enable_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] locked;
`ifdef CLKDIV_SYNC_EN
  logic              sync;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  clkdiv_enable_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ce        (ce),
    .sq        (sq),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare all outputs 1 time unit later
  task automatic cyc(input string tag, input logic [2:0] e_ce, input logic [2:0] e_sq,
                     input logic [2:0] e_lk, input logic e_rdy);
    @(posedge clk);
    #1;
    chk({tag, ".ce"}, ce, e_ce);
    chk({tag, ".sq"}, sq, e_sq);
    chk({tag, ".locked"}, locked, e_lk);
    chk({tag, ".cfg_ready"}, {2'b00, cfg_ready}, {2'b00, e_rdy});
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
    sync      = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc("reset", 3'b000, 3'b000, 3'b000, 1'b1);
    rst_n = 1'b1;

    // Default divide-by-2 on every channel, lock with first ce
    cyc("c1", 3'b000, 3'b111, 3'b000, 1'b1);
    cyc("c2", 3'b111, 3'b000, 3'b111, 1'b1);
    cyc("c3", 3'b000, 3'b111, 3'b111, 1'b1);
    cyc("c4", 3'b111, 3'b000, 3'b111, 1'b1);
    cyc("c5", 3'b000, 3'b111, 3'b111, 1'b1);
    cyc("c6", 3'b111, 3'b000, 3'b111, 1'b1);

    // ch1 -> N=5, applied at the next ch1 wrap (edge 8)
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    cyc("c7", 3'b000, 3'b111, 3'b101, 1'b0);
    cfg_valid = 1'b0;
    cyc("c8",  3'b111, 3'b000, 3'b101, 1'b1);
    cyc("c9",  3'b000, 3'b111, 3'b101, 1'b1);
    cyc("c10", 3'b101, 3'b010, 3'b101, 1'b1);
    cyc("c11", 3'b000, 3'b101, 3'b101, 1'b1);
    cyc("c12", 3'b101, 3'b000, 3'b101, 1'b1);
    cyc("c13", 3'b010, 3'b101, 3'b111, 1'b1);
    cyc("c14", 3'b101, 3'b010, 3'b111, 1'b1);
    cyc("c15", 3'b000, 3'b111, 3'b111, 1'b1);
    cyc("c16", 3'b101, 3'b000, 3'b111, 1'b1);
    cyc("c17", 3'b000, 3'b101, 3'b111, 1'b1);
    cyc("c18", 3'b111, 3'b000, 3'b111, 1'b1);

    // ch0 -> N=0 and ch2 -> N=1: both become ce every cycle, sq low
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
    cyc("c19", 3'b000, 3'b111, 3'b110, 1'b0);
    cfg_valid = 1'b0;
    cyc("c20", 3'b101, 3'b010, 3'b110, 1'b1);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
    cyc("c21", 3'b001, 3'b100, 3'b011, 1'b0);
    cfg_valid = 1'b0;
    cyc("c22", 3'b101, 3'b000, 3'b011, 1'b1);
    cyc("c23", 3'b111, 3'b000, 3'b111, 1'b1);
    cyc("c24", 3'b101, 3'b010, 3'b111, 1'b1);

    // ch1 -> N=3, then a second request (ch0 -> N=2) held until ch1 applies;
    // it is accepted on a ch0 wrap, so ch0 completes that period and switches one wrap later
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    cyc("c25", 3'b101, 3'b010, 3'b101, 1'b0);
    cfg_ch = 2'd0; cfg_div = 8'd2;
    cyc("c26", 3'b101, 3'b000, 3'b101, 1'b0);
    cyc("c27", 3'b101, 3'b000, 3'b101, 1'b0);
    cyc("c28", 3'b111, 3'b000, 3'b101, 1'b1);
    cyc("c29", 3'b101, 3'b010, 3'b100, 1'b0);
    cfg_valid = 1'b0;
    cyc("c30", 3'b101, 3'b000, 3'b100, 1'b1);
    cyc("c31", 3'b110, 3'b001, 3'b110, 1'b1);
    cyc("c32", 3'b101, 3'b010, 3'b111, 1'b1);

    // Out-of-range channel: handshake completes, nothing changes
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
    cyc("c33", 3'b100, 3'b001, 3'b111, 1'b1);
    cfg_valid = 1'b0;
    cyc("c34", 3'b111, 3'b000, 3'b111, 1'b1);
    cyc("c35", 3'b100, 3'b011, 3'b111, 1'b1);

    // Reset during PEND discards ch1 -> N=6 and restores divide-by-2
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd6;
    cyc("c36", 3'b101, 3'b000, 3'b101, 1'b0);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    cyc("c37_rst", 3'b000, 3'b000, 3'b000, 1'b1);
    rst_n = 1'b1;
    cyc("r1", 3'b000, 3'b111, 3'b000, 1'b1);
    cyc("r2", 3'b111, 3'b000, 3'b111, 1'b1);
    cyc("r3", 3'b000, 3'b111, 3'b111, 1'b1);
    cyc("r4", 3'b111, 3'b000, 3'b111, 1'b1);

`ifdef CLKDIV_SYNC_EN
    // ch0 -> 3 applied normally, ch1 -> 6 left pending, then sync aligns all channels
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
    @(posedge clk); #1;
    chk("s42.cfg_ready", {2'b00, cfg_ready}, 3'b000);
    cfg_ch = 2'd1; cfg_div = 8'd6;
    @(posedge clk); #1;
    chk("s43.cfg_ready", {2'b00, cfg_ready}, 3'b001);
    @(posedge clk); #1;
    chk("s44.cfg_ready", {2'b00, cfg_ready}, 3'b000);
    cfg_valid = 1'b0;
    sync = 1'b1;
    cyc("s45", 3'b000, 3'b111, 3'b000, 1'b1);
    sync = 1'b0;
    cyc("s46", 3'b000, 3'b111, 3'b000, 1'b1);
    cyc("s47", 3'b100, 3'b010, 3'b100, 1'b1);
    cyc("s48", 3'b001, 3'b110, 3'b101, 1'b1);
    cyc("s49", 3'b100, 3'b001, 3'b101, 1'b1);
    cyc("s50", 3'b000, 3'b100, 3'b101, 1'b1);
    cyc("s51", 3'b111, 3'b000, 3'b111, 1'b1);
    cyc("s52", 3'b000, 3'b111, 3'b111, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
